// File: rtl/sound_pkg.sv
// Shared constants for the sound unit: frame-sequencer step decode masks,
// length-counter limits and channel indices.
package sound_pkg;

  // Bit n of each mask is set when step n carries that tick.
  localparam logic [7:0] STEP_LEN   = 8'h55;
  localparam logic [7:0] STEP_SWEEP = 8'h44;
  localparam logic [7:0] STEP_ENV   = 8'h80;

  localparam int LEN_MAX_SQ   = 64;
  localparam int LEN_MAX_WAVE = 256;

  typedef enum logic [1:0] {
    CH_SQ1   = 2'd0,
    CH_SQ2   = 2'd1,
    CH_WAVE  = 2'd2,
    CH_NOISE = 2'd3
  } chan_e;

endpackage

// File: rtl/sound_sequencer_length_timer.sv
// Per-channel length counter: NRx1 load, trigger reload of an empty counter,
// decrement on the length tick and a one-cycle expiry flag.
module length_timer
  import sound_pkg::*;
#(
  parameter int W   = 7,
  parameter int MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       len_wr,
  input  logic       len_en_data,
  input  logic       trig,
  input  logic       tick,
  output logic       expire
);

  localparam logic [7:0]   LOAD_MASK = 8'(MAX - 1);
  localparam logic [W-1:0] MAX_CNT   = W'(MAX);

  logic [W-1:0] cnt_reg, cnt_next, load_cnt;
  logic         len_en_reg;

  assign load_cnt = MAX_CNT - W'(load_data & LOAD_MASK);

  // Load first, then the trigger reload sees the loaded value; either one
  // suppresses the decrement for that cycle.
  always_comb begin
    cnt_next = cnt_reg;
    expire   = 1'b0;
    if (load) begin
      cnt_next = load_cnt;
    end
    if (trig) begin
      if (cnt_next == '0) begin
        cnt_next = MAX_CNT;
      end
    end else if (!load && tick && len_en_reg && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - W'(1);
      expire   = (cnt_reg == W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      len_en_reg <= 1'b0;
    end else if (!enable) begin
      cnt_reg    <= '0;
      len_en_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (len_wr) begin
        len_en_reg <= len_en_data;
      end
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Frame sequencer and channel-status controller: 512 Hz step prescaler,
// tick decode, NRx4 trigger strobes, length timers and NR52 active bits.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int DIV   = 32768,
  parameter int DIV_W = 15
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       master_en,
  input  logic [3:0] nrx1_wr,
  input  logic [3:0] nrx4_wr,
  input  logic [7:0] nrx1_data,
  input  logic [7:0] nrx4_data,
  input  logic [3:0] dac_on,
  input  logic       sweep_overflow,
  output logic       tick_length,
  output logic       tick_sweep,
  output logic       tick_envelope,
  output logic [2:0] step,
  output logic [3:0] trigger,
  output logic [3:0] chan_active
);

  localparam logic [DIV_W-1:0] PRESCALE_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] prescaler_reg;
  logic [2:0]       step_reg, step_next;
  logic             tick_length_reg, tick_sweep_reg, tick_envelope_reg;
  logic [3:0]       trigger_reg, active_reg, active_next;
  logic [3:0]       trig_req, expire;
  logic             unused_nrx4_bits;

  assign trig_req         = nrx4_wr & {4{nrx4_data[7]}};
  assign step_next        = step_reg + 3'd1;
  assign unused_nrx4_bits = ^nrx4_data[5:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_len
      localparam bit IS_WAVE = (gi == int'(CH_WAVE));
      length_timer #(
        .W   (IS_WAVE ? 9 : 7),
        .MAX (IS_WAVE ? LEN_MAX_WAVE : LEN_MAX_SQ)
      ) u_length_timer (
        .clk         (system_clock),
        .rst         (reset),
        .enable      (master_en),
        .load        (nrx1_wr[gi]),
        .load_data   (nrx1_data),
        .len_wr      (nrx4_wr[gi]),
        .len_en_data (nrx4_data[6]),
        .trig        (trig_req[gi]),
        .tick        (tick_length_reg),
        .expire      (expire[gi])
      );
    end
  endgenerate

  // Loss of the DAC or a sweep overflow outranks a trigger in the same cycle.
  always_comb begin
    active_next = active_reg;
    for (int i = 0; i < 4; i++) begin
      if (trig_req[i]) begin
        active_next[i] = dac_on[i];
      end
      if (expire[i] || !dac_on[i]) begin
        active_next[i] = 1'b0;
      end
    end
    if (sweep_overflow) begin
      active_next[int'(CH_SQ1)] = 1'b0;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      prescaler_reg     <= '0;
      step_reg          <= 3'd7;
      tick_length_reg   <= 1'b0;
      tick_sweep_reg    <= 1'b0;
      tick_envelope_reg <= 1'b0;
      trigger_reg       <= '0;
      active_reg        <= '0;
    end else if (!master_en) begin
      prescaler_reg     <= '0;
      step_reg          <= 3'd7;
      tick_length_reg   <= 1'b0;
      tick_sweep_reg    <= 1'b0;
      tick_envelope_reg <= 1'b0;
      trigger_reg       <= '0;
      active_reg        <= '0;
    end else begin
      tick_length_reg   <= 1'b0;
      tick_sweep_reg    <= 1'b0;
      tick_envelope_reg <= 1'b0;
      if (prescaler_reg == PRESCALE_LAST) begin
        prescaler_reg     <= '0;
        step_reg          <= step_next;
        tick_length_reg   <= STEP_LEN[step_next];
        tick_sweep_reg    <= STEP_SWEEP[step_next];
        tick_envelope_reg <= STEP_ENV[step_next];
      end else begin
        prescaler_reg <= prescaler_reg + DIV_W'(1);
      end
      trigger_reg <= trig_req;
      active_reg  <= active_next;
    end
  end

  assign tick_length   = tick_length_reg;
  assign tick_sweep    = tick_sweep_reg;
  assign tick_envelope = tick_envelope_reg;
  assign step          = step_reg;
  assign trigger       = trigger_reg;
  assign chan_active   = active_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with a 4-cycle sequencer step.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       master_en;
  logic [3:0] nrx1_wr, nrx4_wr, dac_on;
  logic [7:0] nrx1_data, nrx4_data;
  logic       sweep_overflow;
  logic       tick_length, tick_sweep, tick_envelope;
  logic [2:0] step;
  logic [3:0] trigger, chan_active;

  int checks = 0;
  int errors = 0;

  sound_sequencer #(.DIV(4), .DIV_W(2)) dut (
    .system_clock   (clk),
    .reset          (rst),
    .master_en      (master_en),
    .nrx1_wr        (nrx1_wr),
    .nrx4_wr        (nrx4_wr),
    .nrx1_data      (nrx1_data),
    .nrx4_data      (nrx4_data),
    .dac_on         (dac_on),
    .sweep_overflow (sweep_overflow),
    .tick_length    (tick_length),
    .tick_sweep     (tick_sweep),
    .tick_envelope  (tick_envelope),
    .step           (step),
    .trigger        (trigger),
    .chan_active    (chan_active)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    nrx1_wr        = 4'b0;
    nrx4_wr        = 4'b0;
    sweep_overflow = 1'b0;
  endtask

  // Walks n length ticks; the channel must be active right before the n-th
  // decrement and inactive right after it.
  task automatic count_ticks(input int ch, input int n, input string name);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    while (seen < n && budget < 5000) begin
      if (tick_length) begin
        seen++;
        if (seen == n) begin
          checks++;
          if (chan_active[ch] !== 1'b1) begin
            errors++;
            $display("FAIL %s_before_last: chan_active[%0d]=%b expected 1 (tick %0d)", name, ch, chan_active[ch], seen);
          end
        end
      end
      cyc();
      budget++;
    end
    checks++;
    if (budget >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: saw %0d ticks expected %0d", name, seen, n);
    end
    checks++;
    if (chan_active[ch] !== 1'b0) begin
      errors++;
      $display("FAIL %s_expired: chan_active[%0d]=%b expected 0", name, ch, chan_active[ch]);
    end
    $display("%s: %0d length ticks counted on ch%0d", name, seen, ch + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; master_en = 1'b1; dac_on = 4'hF;
    nrx1_data = 8'h00; nrx4_data = 8'h00;
    clear_writes();
    repeat (2) cyc();
    checks++;
    if ({step, tick_length, tick_sweep, tick_envelope, trigger, chan_active} !== {3'd7, 3'b000, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: step=%0d ticks=%b%b%b trig=%b act=%b expected step=7 rest 0",
               step, tick_length, tick_sweep, tick_envelope, trigger, chan_active);
    end
    rst = 1'b0;
    $display("test_reset: step=%0d act=%b", step, chan_active);
  endtask

  task automatic test_frame_sequence();
    logic [2:0] exp_step;
    logic       exp_len, exp_sw, exp_env;
    for (int k = 0; k < 10; k++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        exp_step = (c == 4) ? 3'(k % 8) : 3'((k + 7) % 8);
        exp_len  = (c == 4) && (exp_step[0] == 1'b0);
        exp_sw   = (c == 4) && (exp_step == 3'd2 || exp_step == 3'd6);
        exp_env  = (c == 4) && (exp_step == 3'd7);
        checks++;
        if ({step, tick_length, tick_sweep, tick_envelope} !== {exp_step, exp_len, exp_sw, exp_env}) begin
          errors++;
          $display("FAIL frame_seq k=%0d c=%0d: step=%0d ticks=%b%b%b expected step=%0d ticks=%b%b%b",
                   k, c, step, tick_length, tick_sweep, tick_envelope, exp_step, exp_len, exp_sw, exp_env);
        end
      end
    end
    $display("test_frame_sequence: 40 cycles, step now %0d", step);
  endtask

  // Issues a triggering NRx4 write with an optional NRx1 load beforehand.
  task automatic load_and_trigger(input int ch, input logic [7:0] len_data, input string name);
    int pending;
    nrx1_wr = 4'(1 << ch); nrx1_data = len_data;
    cyc();
    clear_writes();
    nrx4_wr = 4'(1 << ch); nrx4_data = 8'hC0;
    cyc();
    clear_writes();
    checks++;
    if (trigger !== 4'(1 << ch) || chan_active[ch] !== 1'b1) begin
      errors++;
      $display("FAIL %s_trigger: trig=%b act=%b expected trig=%b act[%0d]=1", name, trigger, chan_active, 4'(1 << ch), ch);
    end
    pending = int'(tick_length);
    cyc();
    checks++;
    if (trigger !== 4'b0) begin
      errors++;
      $display("FAIL %s_strobe_width: trig=%b expected 0000", name, trigger);
    end
    count_ticks(ch, (ch == 2 ? 256 : 64 - int'(len_data[5:0])) - pending, name);
  endtask

  task automatic test_length_sq1();
    load_and_trigger(0, 8'h3E, "len_sq1");
  endtask

  task automatic test_length_wave();
    load_and_trigger(2, 8'h00, "len_wave");
  endtask

  task automatic test_trigger_reload();
    int budget;
    nrx4_wr = 4'b0010; nrx4_data = 8'h40;
    cyc();
    clear_writes();
    checks++;
    if (trigger !== 4'b0 || chan_active[1] !== 1'b0) begin
      errors++;
      $display("FAIL reload_lenen_only: trig=%b act=%b expected trig=0000 act[1]=0", trigger, chan_active);
    end
    budget = 0;
    while (!tick_length && budget < 100) begin
      cyc();
      budget++;
    end
    checks++;
    if (!tick_length) begin
      errors++;
      $display("FAIL reload_wait_tick: tick_length=%b expected 1 within 100 cycles", tick_length);
    end
    nrx4_wr = 4'b0010; nrx4_data = 8'hC0;
    cyc();
    clear_writes();
    checks++;
    if (trigger !== 4'b0010 || chan_active[1] !== 1'b1) begin
      errors++;
      $display("FAIL reload_trigger: trig=%b act=%b expected trig=0010 act[1]=1", trigger, chan_active);
    end
    cyc();
    count_ticks(1, 64, "reload_sq2");
  endtask

  task automatic test_priority();
    nrx4_wr = 4'b0001; nrx4_data = 8'h80; sweep_overflow = 1'b1;
    cyc();
    clear_writes();
    checks++;
    if (trigger !== 4'b0001 || chan_active[0] !== 1'b0) begin
      errors++;
      $display("FAIL prio_sweep: trig=%b act=%b expected trig=0001 act[0]=0", trigger, chan_active);
    end
    dac_on = 4'b0111;
    nrx4_wr = 4'b1000; nrx4_data = 8'h80;
    cyc();
    clear_writes();
    checks++;
    if (trigger !== 4'b1000 || chan_active[3] !== 1'b0) begin
      errors++;
      $display("FAIL prio_dac_off: trig=%b act=%b expected trig=1000 act[3]=0", trigger, chan_active);
    end
    dac_on = 4'hF;
    nrx4_wr = 4'b1000; nrx4_data = 8'h80;
    cyc();
    clear_writes();
    checks++;
    if (chan_active[3] !== 1'b1) begin
      errors++;
      $display("FAIL prio_dac_on: act=%b expected act[3]=1", chan_active);
    end
    $display("test_priority: act=%b", chan_active);
  endtask

  task automatic test_master_disable();
    int budget;
    nrx4_wr = 4'hF; nrx4_data = 8'h80;
    cyc();
    clear_writes();
    checks++;
    if (chan_active !== 4'hF) begin
      errors++;
      $display("FAIL master_all_active: act=%b expected 1111", chan_active);
    end
    budget = 0;
    while (step != 3'd3 && budget < 100) begin
      cyc();
      budget++;
    end
    cyc();
    checks++;
    if (step !== 3'd3) begin
      errors++;
      $display("FAIL master_mid_step: step=%0d expected 3", step);
    end
    master_en = 1'b0;
    nrx1_wr = 4'hF; nrx4_wr = 4'hF; nrx4_data = 8'hC0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if ({step, tick_length, tick_sweep, tick_envelope, trigger, chan_active} !== {3'd7, 3'b000, 4'h0, 4'h0}) begin
        errors++;
        $display("FAIL master_off c=%0d: step=%0d ticks=%b%b%b trig=%b act=%b expected step=7 rest 0",
                 c, step, tick_length, tick_sweep, tick_envelope, trigger, chan_active);
      end
    end
    clear_writes();
    master_en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++;
      if ({step, tick_length, tick_sweep, tick_envelope, trigger, chan_active} !==
          {(c == 4) ? 3'd0 : 3'd7, (c == 4), 2'b00, 4'h0, 4'h0}) begin
        errors++;
        $display("FAIL master_restart c=%0d: step=%0d ticks=%b%b%b trig=%b act=%b",
                 c, step, tick_length, tick_sweep, tick_envelope, trigger, chan_active);
      end
    end
    $display("test_master_disable: restarted at step %0d", step);
  endtask

  task automatic test_async_reset();
    nrx4_wr = 4'b0001; nrx4_data = 8'h80;
    cyc();
    clear_writes();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({step, tick_length, trigger, chan_active} !== {3'd7, 1'b0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL async_reset: step=%0d tick_len=%b trig=%b act=%b expected step=7 rest 0",
               step, tick_length, trigger, chan_active);
    end
    cyc();
    rst = 1'b0;
    $display("test_async_reset: step=%0d", step);
  endtask

  initial begin
    test_reset();
    test_frame_sequence();
    test_length_sq1();
    test_length_wave();
    test_trigger_reload();
    test_priority();
    test_master_disable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
